// File: rtl/move_scheduler_if.sv
// Wall-probe handshake between the movement controller (master) and the maze lookup (slave).
interface move_scheduler_if;
  logic       probe_req;
  logic [9:0] probe_x;
  logic [9:0] probe_y;
  logic       probe_ack;
  logic       probe_blocked;

  modport master (
    output probe_req,
    output probe_x,
    output probe_y,
    input  probe_ack,
    input  probe_blocked
  );

  modport slave (
    input  probe_req,
    input  probe_x,
    input  probe_y,
    output probe_ack,
    output probe_blocked
  );
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: once-per-frame player movement with wall probing of candidate positions.
// Optional macro WRAP_TUNNEL_EN: horizontal screen limits wrap to the opposite side.
module move_scheduler #(
  parameter int X_CENTER      = 280,
  parameter int Y_CENTER      = 334,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int STEP          = 1,
  parameter int SIZE          = 4,
  parameter int PROBE_TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  input  logic [7:0]       keycode,
  move_scheduler_if.master probe_bus,
  output logic [9:0]       pos_x,
  output logic [9:0]       pos_y,
  output logic [1:0]       dir,
  output logic             moving,
  output logic             update_done,
  output logic             overrun
);

  localparam int TW = (PROBE_TIMEOUT > 1) ? $clog2(PROBE_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, PROBE_WANT, PROBE_CUR, COMMIT} state_t;

  state_t          state, state_n;
  logic [1:0]      want_dir, want_dir_n;
  logic            has_want, has_want_n;
  logic [1:0]      snap_dir, snap_dir_n;
  logic            do_move, do_move_n;
  logic [TW-1:0]   timer, timer_n;
  logic [9:0]      pos_x_n, pos_y_n;
  logic [1:0]      dir_n;
  logic            moving_n, update_done_n, overrun_n;
  logic            probe_req_n;
  logic [9:0]      probe_x_n, probe_y_n;

  logic [1:0]      test_dir;
  logic [9:0]      cand_x, cand_y;
  logic            cand_oob;
  logic            probe_done, probe_clear;

  // Candidate is one step from the committed position along the direction under test.
  always_comb begin
    test_dir = (state == PROBE_WANT) ? snap_dir : dir;
    cand_x   = pos_x;
    cand_y   = pos_y;
    case (test_dir)
      2'd0:    cand_x = pos_x + 10'(STEP);
      2'd1:    cand_x = pos_x - 10'(STEP);
      2'd2:    cand_y = pos_y + 10'(STEP);
      default: cand_y = pos_y - 10'(STEP);
    endcase
`ifdef WRAP_TUNNEL_EN
    if (!test_dir[1]) begin
      if (({1'b0, cand_x} + 11'(SIZE)) > 11'(X_MAX)) cand_x = 10'(SIZE);
      else if (cand_x < 10'(SIZE))                  cand_x = 10'(X_MAX - SIZE);
    end
`endif
    cand_oob = (({1'b0, cand_x} + 11'(SIZE)) > 11'(X_MAX)) ||
               (cand_x < 10'(SIZE)) ||
               (({1'b0, cand_y} + 11'(SIZE)) > 11'(Y_MAX)) ||
               (cand_y < 10'(SIZE));
  end

  always_comb begin
    state_n       = state;
    want_dir_n    = want_dir;
    has_want_n    = has_want;
    snap_dir_n    = snap_dir;
    do_move_n     = do_move;
    timer_n       = timer;
    pos_x_n       = pos_x;
    pos_y_n       = pos_y;
    dir_n         = dir;
    moving_n      = moving;
    update_done_n = 1'b0;
    overrun_n     = overrun;
    probe_req_n   = probe_bus.probe_req;
    probe_x_n     = probe_bus.probe_x;
    probe_y_n     = probe_bus.probe_y;
    probe_done    = 1'b0;
    probe_clear   = 1'b0;

    if (frame_start && (state != IDLE)) overrun_n = 1'b1;

    case (state)
      IDLE: begin
        if (frame_start) begin
          do_move_n = 1'b0;
          if (has_want) begin
            snap_dir_n = want_dir;
            state_n    = PROBE_WANT;
          end else if (moving) begin
            state_n = PROBE_CUR;
          end else begin
            state_n = COMMIT;
          end
        end
      end

      PROBE_WANT, PROBE_CUR: begin
        // An off-screen candidate resolves as blocked without ever raising probe_req.
        if (!probe_bus.probe_req) begin
          if (cand_oob) begin
            probe_done = 1'b1;
          end else begin
            probe_req_n = 1'b1;
            probe_x_n   = cand_x;
            probe_y_n   = cand_y;
            timer_n     = '0;
          end
        end else if (probe_bus.probe_ack) begin
          probe_done  = 1'b1;
          probe_clear = !probe_bus.probe_blocked;
        end else if (timer == TW'(PROBE_TIMEOUT - 1)) begin
          probe_done = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end

        if (probe_done) begin
          probe_req_n = 1'b0;
          if (probe_clear) begin
            do_move_n = 1'b1;
            moving_n  = 1'b1;
            state_n   = COMMIT;
            if (state == PROBE_WANT) begin
              dir_n = snap_dir;
              if (want_dir == snap_dir) has_want_n = 1'b0;
            end
          end else if ((state == PROBE_WANT) && moving) begin
            state_n = PROBE_CUR;
          end else begin
            moving_n = 1'b0;
            state_n  = COMMIT;
          end
        end
      end

      COMMIT: begin
        update_done_n = 1'b1;
        if (do_move) begin
          pos_x_n = probe_bus.probe_x;
          pos_y_n = probe_bus.probe_y;
        end
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // A fresh keypress in the same cycle outranks clearing the request.
    case (keycode)
      8'h07: begin want_dir_n = 2'd0; has_want_n = 1'b1; end
      8'h04: begin want_dir_n = 2'd1; has_want_n = 1'b1; end
      8'h16: begin want_dir_n = 2'd2; has_want_n = 1'b1; end
      8'h1A: begin want_dir_n = 2'd3; has_want_n = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state                   <= IDLE;
      want_dir                <= 2'd0;
      has_want                <= 1'b0;
      snap_dir                <= 2'd0;
      do_move                 <= 1'b0;
      timer                   <= '0;
      pos_x                   <= 10'(X_CENTER);
      pos_y                   <= 10'(Y_CENTER);
      dir                     <= 2'd0;
      moving                  <= 1'b0;
      update_done             <= 1'b0;
      overrun                 <= 1'b0;
      probe_bus.probe_req     <= 1'b0;
      probe_bus.probe_x       <= 10'd0;
      probe_bus.probe_y       <= 10'd0;
    end else begin
      state                   <= state_n;
      want_dir                <= want_dir_n;
      has_want                <= has_want_n;
      snap_dir                <= snap_dir_n;
      do_move                 <= do_move_n;
      timer                   <= timer_n;
      pos_x                   <= pos_x_n;
      pos_y                   <= pos_y_n;
      dir                     <= dir_n;
      moving                  <= moving_n;
      update_done             <= update_done_n;
      overrun                 <= overrun_n;
      probe_bus.probe_req     <= probe_req_n;
      probe_bus.probe_x       <= probe_x_n;
      probe_bus.probe_y       <= probe_y_n;
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Testbench for move_scheduler: directed frames plus a randomized walk against a per-frame model.
module tb_move_scheduler;

  localparam int X_CENTER      = 280;
  localparam int Y_CENTER      = 334;
  localparam int X_MAX         = 639;
  localparam int Y_MAX         = 479;
  localparam int STEP          = 1;
  localparam int SIZE          = 4;
  localparam int PROBE_TIMEOUT = 15;
  localparam int M_CLEAR       = 0;
  localparam int M_BLOCK       = 1;
  localparam int M_TIMEOUT     = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] pos_x, pos_y;
  logic [1:0] dir;
  logic       moving, update_done, overrun;

  move_scheduler_if bus();

  move_scheduler dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .keycode(keycode),
    .probe_bus(bus), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
    .update_done(update_done), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nErrors = 0;

  int mx, my, mdir, mwant;
  bit mmoving, mhaswant, moverrun;
  int candX, candY;
  bit lastProbed, allowMidKey, forceClearAll;
  int forcedQ[$];

  task automatic checkOutput(input string tag, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nErrors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mx = X_CENTER; my = Y_CENTER; mdir = 0; mwant = 0;
    mmoving = 0; mhaswant = 0; moverrun = 0;
  endtask

  function automatic logic [7:0] keyOf(input int d);
    case (d)
      0:       return 8'h07;
      1:       return 8'h04;
      2:       return 8'h16;
      default: return 8'h1A;
    endcase
  endfunction

  function automatic int decodeKey(input logic [7:0] k);
    case (k)
      8'h07:   return 0;
      8'h04:   return 1;
      8'h16:   return 2;
      8'h1A:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic void candOf(input int d, output int cx, output int cy, output bit oob);
    cx = mx; cy = my;
    case (d)
      0:       cx = mx + STEP;
      1:       cx = mx - STEP;
      2:       cy = my + STEP;
      default: cy = my - STEP;
    endcase
`ifdef WRAP_TUNNEL_EN
    if (d < 2) begin
      if (cx + SIZE > X_MAX) cx = SIZE;
      else if (cx < SIZE)    cx = X_MAX - SIZE;
    end
`endif
    oob = (cx + SIZE > X_MAX) || (cx < SIZE) || (cy + SIZE > Y_MAX) || (cy < SIZE);
  endfunction

  task automatic applyStimulus(input logic [7:0] k);
    int d;
    @(negedge Clk) keycode = k;
    @(negedge Clk) keycode = 8'h00;
    d = decodeKey(k);
    if (d >= 0) begin mwant = d; mhaswant = 1; end
  endtask

  // Acts as the maze lookup for one probe; returns whether the model sees it as blocked.
  task automatic doProbe(input int d, output bit blocked);
    int cx, cy, mode, delay, b, cnt, kd;
    bit oob;
    candOf(d, cx, cy, oob);
    candX = cx; candY = cy;
    if (oob) begin
      blocked = 1; lastProbed = 0;
      return;
    end
    b = 0;
    while (!bus.probe_req && b < 20) begin @(negedge Clk); b++; end
    checkOutput("probe_rise", bus.probe_req, 1);
    checkOutput("probe_x", bus.probe_x, cx);
    checkOutput("probe_y", bus.probe_y, cy);
    if (forcedQ.size() > 0)  mode = forcedQ.pop_front();
    else if (forceClearAll)  mode = M_CLEAR;
    else begin
      b = $urandom_range(0, 19);
      mode = (b < 10) ? M_CLEAR : (b < 17) ? M_BLOCK : M_TIMEOUT;
    end
    lastProbed = 1;
    if (mode == M_TIMEOUT) begin
      cnt = 0;
      while (bus.probe_req && cnt < 40) begin cnt++; @(negedge Clk); end
      checkOutput("timeout_len", cnt, PROBE_TIMEOUT);
      blocked = 1;
    end else begin
      delay = $urandom_range(0, 3);
      for (int i = 0; i < delay; i++) begin
        if (i == 0 && allowMidKey && $urandom_range(0, 2) == 0) begin
          kd = $urandom_range(0, 3);
          keycode = keyOf(kd);
          mwant = kd; mhaswant = 1;
        end
        @(negedge Clk);
        keycode = 8'h00;
        checkOutput("probe_hold", bus.probe_req, 1);
        checkOutput("probe_x_stable", bus.probe_x, cx);
      end
      bus.probe_ack = 1'b1;
      bus.probe_blocked = (mode == M_BLOCK);
      @(negedge Clk);
      bus.probe_ack = 1'b0;
      bus.probe_blocked = 1'($urandom_range(0, 1));
      checkOutput("probe_drop", bus.probe_req, 0);
      blocked = (mode == M_BLOCK);
    end
  endtask

  task automatic runFrame(input bit extra);
    int ox, oy, snap, b;
    bit blk, anyStage;
    ox = mx; oy = my; anyStage = 0; lastProbed = 0;
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk);
    if (extra) begin moverrun = 1; @(negedge Clk); end
    frame_start = 1'b0;

    if (mhaswant) begin
      anyStage = 1;
      snap = mwant;
      doProbe(snap, blk);
      if (!blk) begin
        mdir = snap; mmoving = 1; mx = candX; my = candY;
        if (mwant == snap) mhaswant = 0;
      end else if (mmoving) begin
        doProbe(mdir, blk);
        if (!blk) begin mx = candX; my = candY; end
        else mmoving = 0;
      end
    end else if (mmoving) begin
      anyStage = 1;
      doProbe(mdir, blk);
      if (!blk) begin mx = candX; my = candY; end
      else mmoving = 0;
    end

    checkOutput("pos_hold_x", pos_x, ox);
    checkOutput("pos_hold_y", pos_y, oy);
    if (!anyStage || lastProbed) begin
      checkOutput("done_early", update_done, 0);
      if (!anyStage) checkOutput("no_probe", bus.probe_req, 0);
      @(negedge Clk);
      checkOutput("done_timing", update_done, 1);
    end
    b = 0;
    while (!update_done && b < 10) begin
      checkOutput("no_probe", bus.probe_req, 0);
      @(negedge Clk);
      b++;
    end
    checkOutput("done_seen", update_done, 1);
    checkOutput("pos_x", pos_x, mx);
    checkOutput("pos_y", pos_y, my);
    checkOutput("dir", dir, mdir);
    checkOutput("moving", moving, mmoving);
    checkOutput("overrun", overrun, moverrun);
    @(negedge Clk);
    checkOutput("done_pulse", update_done, 0);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b, r;
    bus.probe_ack = 1'b0;
    bus.probe_blocked = 1'b0;
    allowMidKey = 0;
    forceClearAll = 0;
    modelReset();

    repeat (3) @(negedge Clk);
    checkOutput("rst_probe_req", bus.probe_req, 0);
    checkOutput("rst_probe_x", bus.probe_x, 0);
    checkOutput("rst_probe_y", bus.probe_y, 0);
    checkOutput("rst_pos_x", pos_x, X_CENTER);
    checkOutput("rst_pos_y", pos_y, Y_CENTER);
    checkOutput("rst_dir", dir, 0);
    checkOutput("rst_moving", moving, 0);
    checkOutput("rst_update_done", update_done, 0);
    checkOutput("rst_overrun", overrun, 0);
    Reset = 1'b0;

    $display("[TB] idle frame with no key");
    runFrame(0);

    $display("[TB] start moving right");
    applyStimulus(8'h07);
    forcedQ.push_back(M_CLEAR);
    runFrame(0);
    forcedQ.push_back(M_CLEAR);
    runFrame(0);

    $display("[TB] blocked turn up, then clear turn");
    applyStimulus(8'h1A);
    forcedQ.push_back(M_BLOCK);
    forcedQ.push_back(M_CLEAR);
    runFrame(0);
    forcedQ.push_back(M_CLEAR);
    runFrame(0);

    $display("[TB] moving left then probe timeout");
    applyStimulus(8'h04);
    forcedQ.push_back(M_CLEAR);
    runFrame(0);
    forcedQ.push_back(M_TIMEOUT);
    runFrame(0);

    $display("[TB] frame_start while busy");
    applyStimulus(8'h16);
    forcedQ.push_back(M_CLEAR);
    runFrame(1);
    forcedQ.push_back(M_CLEAR);
    runFrame(0);

    $display("[TB] reset in the middle of a probe");
    applyStimulus(8'h07);
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk) frame_start = 1'b0;
    b = 0;
    while (!bus.probe_req && b < 20) begin @(negedge Clk); b++; end
    checkOutput("midrst_probe_seen", bus.probe_req, 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    modelReset();
    checkOutput("midrst_probe_req", bus.probe_req, 0);
    checkOutput("midrst_pos_x", pos_x, X_CENTER);
    checkOutput("midrst_pos_y", pos_y, Y_CENTER);
    checkOutput("midrst_moving", moving, 0);
    checkOutput("midrst_overrun", overrun, 0);
    runFrame(0);

    $display("[TB] run to the right screen limit");
    forceClearAll = 1;
    applyStimulus(8'h07);
    b = 0;
    while (mx < X_MAX - SIZE && b < 400) begin runFrame(0); b++; end
    checkOutput("edge_pos_x", pos_x, X_MAX - SIZE);
    runFrame(0);
    applyStimulus(8'h04);
    runFrame(0);
    forceClearAll = 0;

    $display("[TB] randomized walk");
    allowMidKey = 1;
    for (int f = 0; f < 120; f++) begin
      r = $urandom_range(0, 5);
      if (r < 4)       applyStimulus(keyOf(r));
      else if (r == 4) applyStimulus(8'h05);
      runFrame(0);
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
